// File: rtl/eth_cmd_depkt.sv
// eth_cmd_depkt: parses 6-byte UDP command packets (55 AA CMD PH PL CHK) into streaming/length controls
// Ports: eth_rx_clk, rst (async, active-high); udp_rec_en/udp_rec_data/udp_rec_pkt_done byte stream in;
//        transfer_flag, udp_tx_byte_num, cmd_code are held settings; cmd_valid/cmd_err are one-cycle result pulses.
// Optional: define CMD_CHECKSUM_EN to require CHK == CMD+PARAM_H+PARAM_L (mod 256).
module eth_cmd_depkt #(
  parameter logic [15:0] DEFAULT_LEN = 16'd512,
  parameter logic [15:0] MAX_LEN     = 16'd1472
) (
  input  logic        eth_rx_clk,
  input  logic        rst,
  input  logic        udp_rec_en,
  input  logic [7:0]  udp_rec_data,
  input  logic        udp_rec_pkt_done,
  output logic        transfer_flag,
  output logic [15:0] udp_tx_byte_num,
  output logic        cmd_valid,
  output logic        cmd_err,
  output logic [7:0]  cmd_code
);
  typedef enum logic [2:0] {IDLE, HDR2, CMD, PH, PL, CHK, DONE, DRAIN} state_t;
  state_t      r_state, w_byte_state, w_next;
  logic [7:0]  r_cmd, r_ph, r_pl;
  logic [15:0] w_param, w_len_nxt;
  logic [7:0]  w_code_nxt;
  logic        w_op_ok, w_chk_ok, w_accept, w_reject, w_flag_nxt;
  always_ff @(posedge eth_rx_clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // w_byte_state is where this cycle's byte (if any) leaves the parser; pkt_done judges that state
  always_comb begin
    w_byte_state = r_state;
    if (udp_rec_en)
      case (r_state)
        IDLE:    w_byte_state = (udp_rec_data == 8'h55) ? HDR2 : DRAIN;
        HDR2:    w_byte_state = (udp_rec_data == 8'hAA) ? CMD : DRAIN;
        CMD:     w_byte_state = PH;
        PH:      w_byte_state = PL;
        PL:      w_byte_state = CHK;
        CHK:     w_byte_state = DONE;
        default: w_byte_state = DRAIN;
      endcase
    w_next = udp_rec_pkt_done ? IDLE : w_byte_state;
  end
`ifdef CMD_CHECKSUM_EN
  logic [7:0] r_chk, w_chk;
  always_ff @(posedge eth_rx_clk or posedge rst)
    if (rst) r_chk <= 8'h00;
    else if (udp_rec_en && r_state == CHK) r_chk <= udp_rec_data;
  // CHK may arrive on the same cycle as pkt_done, so bypass the latch
  assign w_chk    = (udp_rec_en && r_state == CHK) ? udp_rec_data : r_chk;
  assign w_chk_ok = w_chk == 8'(r_cmd + r_ph + r_pl);
`else
  assign w_chk_ok = 1'b1;
`endif
  always_comb begin
    w_param    = {r_ph, r_pl};
    w_op_ok    = (r_cmd == 8'h01) || (r_cmd == 8'h02) ||
                 (r_cmd == 8'h03 && w_param != 16'd0 && w_param <= MAX_LEN);
    w_accept   = udp_rec_pkt_done && w_byte_state == DONE && w_op_ok && w_chk_ok;
    w_reject   = udp_rec_pkt_done && !w_accept;
    w_flag_nxt = (w_accept && r_cmd == 8'h01) ? 1'b1 :
                 (w_accept && r_cmd == 8'h02) ? 1'b0 : transfer_flag;
    w_len_nxt  = (w_accept && r_cmd == 8'h03) ? w_param : udp_tx_byte_num;
    w_code_nxt = w_accept ? r_cmd : cmd_code;
  end
  always_ff @(posedge eth_rx_clk or posedge rst)
    if (rst) begin
      r_cmd           <= 8'h00;
      r_ph            <= 8'h00;
      r_pl            <= 8'h00;
      transfer_flag   <= 1'b0;
      udp_tx_byte_num <= DEFAULT_LEN;
      cmd_valid       <= 1'b0;
      cmd_err         <= 1'b0;
      cmd_code        <= 8'h00;
    end else begin
      if (udp_rec_en && r_state == CMD) r_cmd <= udp_rec_data;
      if (udp_rec_en && r_state == PH) r_ph <= udp_rec_data;
      if (udp_rec_en && r_state == PL) r_pl <= udp_rec_data;
      transfer_flag   <= w_flag_nxt;
      udp_tx_byte_num <= w_len_nxt;
      cmd_valid       <= w_accept;
      cmd_err         <= w_reject;
      cmd_code        <= w_code_nxt;
    end
endmodule

// File: tb/tb_eth_cmd_depkt.sv
// tb_eth_cmd_depkt: table vectors, hand sequences and random packets checked against a packet-level model
module tb_eth_cmd_depkt;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, done = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        transfer_flag, cmd_valid, cmd_err;
  logic [15:0] udp_tx_byte_num;
  logic [7:0]  cmd_code;
  int tests = 0, fails = 0, n_valid = 0;
  logic        e_valid = 1'b0, e_err = 1'b0, e_flag = 1'b0;
  logic [15:0] e_len = 16'd512;
  logic [7:0]  e_code = 8'h00;
  logic [7:0]  q[$];
  eth_cmd_depkt dut (
    .eth_rx_clk(clk), .rst(rst), .udp_rec_en(en), .udp_rec_data(data), .udp_rec_pkt_done(done),
    .transfer_flag(transfer_flag), .udp_tx_byte_num(udp_tx_byte_num), .cmd_valid(cmd_valid),
    .cmd_err(cmd_err), .cmd_code(cmd_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, {15'd0, cmd_valid}, {15'd0, e_valid});
    chk({tag, ".err"}, {15'd0, cmd_err}, {15'd0, e_err});
    chk({tag, ".flag"}, {15'd0, transfer_flag}, {15'd0, e_flag});
    chk({tag, ".len"}, udp_tx_byte_num, e_len);
    chk({tag, ".code"}, {8'd0, cmd_code}, {8'd0, e_code});
  endtask
  // packet-level model: a packet is a whole byte list judged when pkt_done arrives
  task automatic judge();
    logic ok;
    logic [15:0] p;
    ok = q.size() == 6 && q[0] == 8'h55 && q[1] == 8'hAA;
`ifdef CMD_CHECKSUM_EN
    if (ok) ok = q[5] == 8'(q[2] + q[3] + q[4]);
`endif
    e_err = 1'b1;
    if (ok) begin
      p = {q[3], q[4]};
      if (q[2] == 8'h01 || q[2] == 8'h02 || (q[2] == 8'h03 && p >= 16'd1 && p <= 16'd1472)) begin
        e_err   = 1'b0;
        e_valid = 1'b1;
        e_code  = q[2];
        if (q[2] == 8'h01) e_flag = 1'b1;
        if (q[2] == 8'h02) e_flag = 1'b0;
        if (q[2] == 8'h03) e_len = p;
      end
    end
  endtask
  task automatic step(input logic s_en, input logic [7:0] d, input logic dn);
    @(negedge clk);
    chk_all("cyc");
    if (cmd_valid === 1'b1) n_valid++;
    en = s_en; data = d; done = dn;
    e_valid = 1'b0; e_err = 1'b0;
    if (s_en) q.push_back(d);
    if (dn) begin judge(); q.delete(); end
  endtask
  task automatic send(input logic [63:0] b, input int n, input bit dl, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, b[63-8*i -: 8], dl && i == n - 1);
    end
    if (!dl) step(1'b0, 8'($urandom), 1'b1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; done = 1'b0;
    q.delete();
    e_valid = 1'b0; e_err = 1'b0; e_flag = 1'b0; e_len = 16'd512; e_code = 8'h00;
    #1 chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
  endtask
  typedef struct {
    logic [63:0] b;
    int          n;
    bit          dl;
    logic        ev, ee, ef;
    logic [15:0] el;
    logic [7:0]  ec;
  } vec_t;
  vec_t vt[14];
  logic f5;
  logic [7:0] c5;
  initial begin
`ifdef CMD_CHECKSUM_EN
    f5 = 1'b0; c5 = 8'h02;
`else
    f5 = 1'b1; c5 = 8'h01;
`endif
    vt[0]  = '{64'h55AA010000010000, 6, 1'b0, 1'b1, 1'b0, 1'b1, 16'd512, 8'h01};
    vt[1]  = '{64'h55AA030400070000, 6, 1'b0, 1'b1, 1'b0, 1'b1, 16'd1024, 8'h03};
    vt[2]  = '{64'h55AA0305DDE50000, 6, 1'b0, 1'b0, 1'b1, 1'b1, 16'd1024, 8'h03};
    vt[3]  = '{64'h55AA020000020000, 6, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1024, 8'h02};
    vt[4]  = '{64'h55AA010000FF0000, 6, 1'b0, f5, ~f5, f5, 16'd1024, c5};
    vt[5]  = '{64'h55AA020000000000, 5, 1'b0, 1'b0, 1'b1, f5, 16'd1024, c5};
    vt[6]  = '{64'h55AA020000020000, 7, 1'b1, 1'b0, 1'b1, f5, 16'd1024, c5};
    vt[7]  = '{64'h55AA020000020000, 6, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1024, 8'h02};
    vt[8]  = '{64'h55AA030000030000, 6, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1024, 8'h02};
    vt[9]  = '{64'h55AA0305C0C80000, 6, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1472, 8'h03};
    vt[10] = '{64'h55AA0305C1C90000, 6, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1472, 8'h03};
    vt[11] = '{64'h55AA040000040000, 6, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1472, 8'h03};
    vt[12] = '{64'h55AB010000010000, 6, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1472, 8'h03};
    vt[13] = '{64'h55AA030001040000, 6, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 8'h03};
    repeat (2) @(negedge clk);
    #1 chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      send(vt[k].b, vt[k].n, vt[k].dl, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      chk($sformatf("vec%0d.valid", k), {15'd0, cmd_valid}, {15'd0, vt[k].ev});
      chk($sformatf("vec%0d.err", k), {15'd0, cmd_err}, {15'd0, vt[k].ee});
      chk($sformatf("vec%0d.flag", k), {15'd0, transfer_flag}, {15'd0, vt[k].ef});
      chk($sformatf("vec%0d.len", k), udp_tx_byte_num, vt[k].el);
      chk($sformatf("vec%0d.code", k), {8'd0, cmd_code}, {8'd0, vt[k].ec});
    end
    // START with pkt_done on its last byte, STOP following with no idle cycle
    n_valid = 0;
    send(64'h55AA010000010000, 6, 1'b1, 1'b0);
    send(64'h55AA020000020000, 6, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("b2b.pulses", 16'(n_valid), 16'd2);
    chk("b2b.flag", {15'd0, transfer_flag}, 16'd0);
    // reset three bytes into a START packet
    send(64'h55AA030200050000, 6, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    do_reset();
    n_valid = 0;
    repeat (4) step(1'b0, 8'h00, 1'b0);
    chk("rst.no_pulse", 16'(n_valid) | {15'd0, cmd_err}, 16'd0);
    send(64'h55AA010000010000, 6, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("rst.next_valid", {15'd0, cmd_valid}, 16'd1);
    chk("rst.next_flag", {15'd0, transfer_flag}, 16'd1);
    // random packets, gaps, lengths, opcodes and checksums
    for (int r = 0; r < 300; r++) begin
      logic [7:0] op, ph, pl, ck;
      logic [15:0] p;
      logic [63:0] b;
      int n;
      op = 8'($urandom_range(0, 4));
      case ($urandom_range(0, 4))
        0: p = 16'($urandom);
        1: p = 16'd0;
        2: p = 16'd1472;
        3: p = 16'd1473;
        default: p = 16'($urandom_range(1, 1472));
      endcase
      ph = p[15:8]; pl = p[7:0];
      ck = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(op + ph + pl);
      b = {8'h55, 8'hAA, op, ph, pl, ck, 8'($urandom), 8'h00};
      if ($urandom_range(0, 9) == 0) b[55:48] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) b[63:56] = 8'($urandom);
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : 6;
      if (n == 0) step(1'b0, 8'($urandom), 1'b1);
      else send(b, n, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) step(1'b0, 8'($urandom), 1'b0);
    end
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
